// File: rtl/header_extraction_pkg.sv
// Shared definitions for the header extraction block: FSM encodings,
// default geometry and the keep-vector helper used on the input side.
package header_extraction_pkg;

    // One-hot state encoding, 8 bits wide.
    typedef enum logic [7:0] {
        ST_HEADER = 8'h01,
        ST_STREAM = 8'h02,
        ST_FLUSH  = 8'h04
    } state_t;

    localparam int DEFAULT_BITS_PER_BEAT = 512;
    localparam int DEFAULT_HEADER_SIZE   = 112;
    localparam int BYTES_PER_BEAT        = DEFAULT_BITS_PER_BEAT / 8;
    localparam int BYTES_PER_HEADER      = DEFAULT_HEADER_SIZE / 8;

    // Widest keep vector the helper accepts; callers zero-extend into it.
    localparam int MAX_KEEP_W = 256;

    // True when any byte above the header region of a beat is enabled.
    function automatic logic keep_upper_nonzero(input logic [MAX_KEEP_W-1:0] keep,
                                                input int header_bytes);
        return |(keep >> header_bytes);
    endfunction

endpackage

// File: rtl/header_extraction_if.sv
// Stream and sideband bundle for header_extraction. The slave modport is
// the extractor itself; the master modport is the surrounding logic.
interface header_extraction_if
    import header_extraction_pkg::*;
#(
    parameter int BITS_PER_BEAT = DEFAULT_BITS_PER_BEAT,
    parameter int HEADER_SIZE   = DEFAULT_HEADER_SIZE
);
    localparam int BB = BITS_PER_BEAT / 8;

    logic                     tready_out;
    logic                     tvalid_in;
    logic [BITS_PER_BEAT-1:0] tdata_in;
    logic                     tlast_in;
    logic [BB-1:0]            tkeep_in;
    logic                     tready_in;
    logic                     tvalid_out;
    logic [BITS_PER_BEAT-1:0] tdata_out;
    logic                     tlast_out;
    logic [BB-1:0]            tkeep_out;
    logic [HEADER_SIZE-1:0]   header_data;
    logic                     header_valid;
    logic                     header_error;

    modport slave (
        input  tvalid_in, tdata_in, tlast_in, tkeep_in, tready_in,
        output tready_out, tvalid_out, tdata_out, tlast_out, tkeep_out,
        output header_data, header_valid, header_error
    );

    modport master (
        output tvalid_in, tdata_in, tlast_in, tkeep_in, tready_in,
        input  tready_out, tvalid_out, tdata_out, tlast_out, tkeep_out,
        input  header_data, header_valid, header_error
    );

endinterface

// File: rtl/header_extraction_axis_register_slice.sv
// Single-entry registered AXI-Stream stage. Accepts a beat whenever the
// register is empty or being drained in the same cycle.
module axis_register_slice #(
    parameter int DATA_W = 512,
    parameter int KEEP_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [KEEP_W-1:0] in_keep,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic              out_last,
    input  logic              out_ready
);

    assign in_ready = !out_valid || out_ready;

    // Output register: load on free slot, otherwise hold while stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
                out_keep <= in_keep;
                out_last <= in_last;
            end
        end
    end

endmodule

// File: rtl/header_extraction.sv
// Strips the leading header bytes of each AXI-Stream packet onto a
// sideband port and realigns the remaining payload down to byte 0.
module header_extraction
    import header_extraction_pkg::*;
#(
    parameter int BITS_PER_BEAT = DEFAULT_BITS_PER_BEAT,
    parameter int HEADER_SIZE   = DEFAULT_HEADER_SIZE
) (
    input  logic              clock,
    input  logic              reset,
    header_extraction_if.slave bus
);

    localparam int B   = BITS_PER_BEAT;
    localparam int H   = HEADER_SIZE;
    localparam int BB  = B / 8;
    localparam int HB  = H / 8;
    localparam int RW  = B - H;
    localparam int RKW = BB - HB;

    state_t state_q, state_d;

    logic [RW-1:0]  resid_data;
    logic [RKW-1:0] resid_keep;
    logic [H-1:0]   hdr_data_q;
    logic           hdr_vld_q, hdr_err_q;

    logic slice_ready, accept, upper_nz, lower_full;

    logic          emit_vld_p0, emit_last_p0;
    logic [B-1:0]  emit_data_p0;
    logic [BB-1:0] emit_keep_p0;
    logic          resid_load_p0, hdr_load_p0, hdr_vld_p0, hdr_err_p0;

    assign bus.tready_out = !reset && (state_q != ST_FLUSH) && slice_ready;
    assign accept         = bus.tvalid_in && bus.tready_out;
    assign upper_nz       = keep_upper_nonzero(MAX_KEEP_W'(bus.tkeep_in), HB);
    assign lower_full     = &bus.tkeep_in[HB-1:0];

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= ST_HEADER;
        else       state_q <= state_d;
    end

    // Next-state: a trailing beat needing a flush diverts through FLUSH.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HEADER: if (accept && !bus.tlast_in) state_d = ST_STREAM;
            ST_STREAM: if (accept && bus.tlast_in)  state_d = upper_nz ? ST_FLUSH : ST_HEADER;
            ST_FLUSH:  if (slice_ready)             state_d = ST_HEADER;
            default:                                state_d = ST_HEADER;
        endcase
    end

    // Output decode: what to emit, and when residue/header registers load.
    always_comb begin
        emit_vld_p0   = 1'b0;
        emit_last_p0  = 1'b0;
        emit_data_p0  = '0;
        emit_keep_p0  = '0;
        resid_load_p0 = 1'b0;
        hdr_load_p0   = 1'b0;
        hdr_vld_p0    = 1'b0;
        hdr_err_p0    = 1'b0;
        case (state_q)
            ST_HEADER: begin
                if (accept) begin
                    resid_load_p0 = 1'b1;
                    hdr_load_p0   = 1'b1;
                    if (!bus.tlast_in) begin
                        hdr_vld_p0 = 1'b1;
                    end else if (upper_nz) begin
                        hdr_vld_p0   = 1'b1;
                        emit_vld_p0  = 1'b1;
                        emit_last_p0 = 1'b1;
                        emit_data_p0 = {{H{1'b0}}, bus.tdata_in[B-1:H]};
                        emit_keep_p0 = {{HB{1'b0}}, bus.tkeep_in[BB-1:HB]};
                    end else if (!lower_full) begin
                        // Runt: packet ends before the header is complete.
                        hdr_err_p0 = 1'b1;
                    end else begin
                        hdr_vld_p0 = 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                if (accept) begin
                    resid_load_p0 = 1'b1;
                    emit_vld_p0   = 1'b1;
                    emit_last_p0  = bus.tlast_in && !upper_nz;
                    emit_data_p0  = {bus.tdata_in[H-1:0], resid_data};
                    emit_keep_p0  = {bus.tkeep_in[HB-1:0], resid_keep};
                end
            end
            ST_FLUSH: begin
                emit_vld_p0  = 1'b1;
                emit_last_p0 = 1'b1;
                emit_data_p0 = {{H{1'b0}}, resid_data};
                emit_keep_p0 = {{HB{1'b0}}, resid_keep};
            end
            default: ;
        endcase
    end

    // Residue carried into the next output beat, plus header sideband.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resid_data <= '0;
            resid_keep <= '0;
            hdr_data_q <= '0;
            hdr_vld_q  <= 1'b0;
            hdr_err_q  <= 1'b0;
        end else begin
            if (resid_load_p0) begin
                resid_data <= bus.tdata_in[B-1:H];
                resid_keep <= bus.tkeep_in[BB-1:HB];
            end
            if (hdr_load_p0) hdr_data_q <= bus.tdata_in[H-1:0];
            hdr_vld_q <= hdr_vld_p0;
            hdr_err_q <= hdr_err_p0;
        end
    end

    assign bus.header_data  = hdr_data_q;
    assign bus.header_valid = hdr_vld_q;
    assign bus.header_error = hdr_err_q;

    axis_register_slice #(.DATA_W(B), .KEEP_W(BB)) u_out_slice (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (emit_vld_p0),
        .in_data   (emit_data_p0),
        .in_keep   (emit_keep_p0),
        .in_last   (emit_last_p0),
        .in_ready  (slice_ready),
        .out_valid (bus.tvalid_out),
        .out_data  (bus.tdata_out),
        .out_keep  (bus.tkeep_out),
        .out_last  (bus.tlast_out),
        .out_ready (bus.tready_in)
    );

endmodule

// File: tb/tb_header_extraction.sv
// Bench for header_extraction: reset values, a directed vector table,
// a mid-packet reset sequence and randomized traffic against a byte-level
// reference model.
module tb_header_extraction;

    localparam int B  = 512;
    localparam int H  = 112;
    localparam int BB = B / 8;
    localparam int HB = H / 8;

    typedef struct {
        logic [B-1:0]  data;
        logic [BB-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct {
        int            nbeats;
        int            last_bytes;
        int            n_out;
        logic [BB-1:0] keep0;
        logic          last0;
        logic [BB-1:0] keep1;
        logic          last1;
        int            n_hdr;
        int            n_err;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    header_extraction_if #(.BITS_PER_BEAT(B), .HEADER_SIZE(H)) bus ();

    header_extraction #(.BITS_PER_BEAT(B), .HEADER_SIZE(H)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    beat_t      obs_q[$];
    beat_t      exp_q[$];
    logic [H-1:0] obs_hdr[$];
    logic [H-1:0] exp_hdr[$];
    int obs_err, exp_err, exp_lasts;
    logic [7:0] cur[$];
    bit rnd_ready = 1'b0;

    task automatic check(input string name, input logic [B-1:0] act, input logic [B-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_all();
        obs_q.delete(); exp_q.delete(); obs_hdr.delete(); exp_hdr.delete();
        obs_err = 0; exp_err = 0; exp_lasts = 0;
    endtask

    // Reference: header is the first HB bytes; payload is everything after,
    // cut into BB-byte beats; a single-beat packet shorter than HB is a runt.
    function automatic void model_packet();
        logic [H-1:0] h;
        beat_t bt;
        int rem, k, n;
        if (cur.size() < HB) begin
            exp_err++;
            return;
        end
        h = '0;
        for (int i = 0; i < HB; i++) h[8*i +: 8] = cur[i];
        exp_hdr.push_back(h);
        rem = cur.size() - HB;
        k = 0;
        while (rem > 0) begin
            n = (rem < BB) ? rem : BB;
            bt.data = '0;
            bt.keep = '0;
            for (int j = 0; j < n; j++) begin
                bt.data[8*j +: 8] = cur[HB + BB*k + j];
                bt.keep[j] = 1'b1;
            end
            bt.last = (rem <= BB);
            if (bt.last) exp_lasts++;
            exp_q.push_back(bt);
            rem -= n;
            k++;
        end
    endfunction

    function automatic logic [B-1:0] keep_mask(input logic [BB-1:0] k);
        logic [B-1:0] m;
        m = '0;
        for (int j = 0; j < BB; j++) if (k[j]) m[8*j +: 8] = 8'hFF;
        return m;
    endfunction

    // Monitor on the falling edge: collect transfers and sideband events,
    // and require a stalled output beat to stay put.
    logic  stall_pend = 1'b0;
    beat_t stall_beat;
    always @(negedge clock) begin
        if (reset) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                check("stall_valid", B'(bus.tvalid_out), B'(1));
                check("stall_data", bus.tdata_out, stall_beat.data);
                check("stall_keep", B'(bus.tkeep_out), B'(stall_beat.keep));
                check("stall_last", B'(bus.tlast_out), B'(stall_beat.last));
            end
            if (bus.tvalid_out && bus.tready_in)
                obs_q.push_back('{data: bus.tdata_out, keep: bus.tkeep_out, last: bus.tlast_out});
            stall_pend = bus.tvalid_out && !bus.tready_in;
            stall_beat = '{data: bus.tdata_out, keep: bus.tkeep_out, last: bus.tlast_out};
            if (bus.header_valid) obs_hdr.push_back(bus.header_data);
            if (bus.header_error) obs_err++;
        end
    end

    // Downstream ready: random when enabled, otherwise always ready.
    always @(posedge clock) begin
        #1;
        bus.tready_in = rnd_ready ? 1'($urandom_range(1, 0)) : 1'b1;
    end

    task automatic wait_idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive_beat(input logic [B-1:0] d, input logic [BB-1:0] k,
                              input logic l, input bit gap);
        int guard;
        if (gap) begin
            while ($urandom_range(1, 0) == 1) begin
                bus.tvalid_in = 1'b0;
                @(posedge clock);
                #1;
            end
        end
        bus.tvalid_in = 1'b1;
        bus.tdata_in  = d;
        bus.tkeep_in  = k;
        bus.tlast_in  = l;
        guard = 0;
        forever begin
            @(negedge clock);
            if (bus.tready_out) break;
            guard++;
            if (guard > 1000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL accept_timeout: got tready_out 0 for %0d cycles, expected 1", guard);
                break;
            end
        end
        @(posedge clock);
        #1;
        bus.tvalid_in = 1'b0;
    endtask

    task automatic send_pkt(input int nbeats, input int last_bytes, input bit rnd_data, input bit gap);
        logic [B-1:0]  d;
        logic [BB-1:0] k;
        int total, nb;
        cur.delete();
        total = (nbeats - 1) * BB + last_bytes;
        for (int i = 0; i < total; i++) cur.push_back(rnd_data ? 8'($urandom) : 8'(i));
        model_packet();
        for (int b = 0; b < nbeats; b++) begin
            d = '0;
            k = '0;
            nb = (b == nbeats - 1) ? last_bytes : BB;
            for (int j = 0; j < nb; j++) begin
                d[8*j +: 8] = cur[BB*b + j];
                k[j] = 1'b1;
            end
            drive_beat(d, k, (b == nbeats - 1), gap);
        end
    endtask

    task automatic compare_streams(input string tag);
        int n, obs_lasts;
        check({tag, "_beats"}, B'(obs_q.size()), B'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        obs_lasts = 0;
        foreach (obs_q[i]) if (obs_q[i].last) obs_lasts++;
        for (int i = 0; i < n; i++) begin
            check({tag, "_keep"}, B'(obs_q[i].keep), B'(exp_q[i].keep));
            check({tag, "_last"}, B'(obs_q[i].last), B'(exp_q[i].last));
            check({tag, "_data"}, obs_q[i].data & keep_mask(exp_q[i].keep), exp_q[i].data);
        end
        check({tag, "_tlast_count"}, B'(obs_lasts), B'(exp_lasts));
        check({tag, "_hdr_count"}, B'(obs_hdr.size()), B'(exp_hdr.size()));
        n = (obs_hdr.size() < exp_hdr.size()) ? obs_hdr.size() : exp_hdr.size();
        for (int i = 0; i < n; i++) check({tag, "_hdr"}, B'(obs_hdr[i]), B'(exp_hdr[i]));
        check({tag, "_err_count"}, B'(obs_err), B'(exp_err));
    endtask

    initial begin
        vec_t vecs[5];
        logic [H-1:0] hexp;
        logic [B-1:0] dexp;
        logic [BB-1:0] kexp;

        vecs[0] = '{2, 20, 2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h3F, 1'b1, 1, 0};
        vecs[1] = '{2, 10, 1, 64'h0FFF_FFFF_FFFF_FFFF, 1'b1, 64'h0,  1'b0, 1, 0};
        vecs[2] = '{1, 64, 1, 64'h0003_FFFF_FFFF_FFFF, 1'b1, 64'h0,  1'b0, 1, 0};
        vecs[3] = '{1, 14, 0, 64'h0,                   1'b0, 64'h0,  1'b0, 1, 0};
        vecs[4] = '{1, 8,  0, 64'h0,                   1'b0, 64'h0,  1'b0, 0, 1};

        reset         = 1'b1;
        bus.tvalid_in = 1'b0;
        bus.tdata_in  = '0;
        bus.tkeep_in  = '0;
        bus.tlast_in  = 1'b0;
        bus.tready_in = 1'b1;
        clear_all();
        #2;
        check("rst_tready_out", B'(bus.tready_out), B'(0));
        check("rst_tvalid_out", B'(bus.tvalid_out), B'(0));
        check("rst_tdata_out", bus.tdata_out, B'(0));
        check("rst_tkeep_out", B'(bus.tkeep_out), B'(0));
        check("rst_tlast_out", B'(bus.tlast_out), B'(0));
        check("rst_header_data", B'(bus.header_data), B'(0));
        check("rst_header_valid", B'(bus.header_valid), B'(0));
        check("rst_header_error", B'(bus.header_error), B'(0));
        wait_idle(2);
        reset = 1'b0;
        wait_idle(1);

        // Directed vectors: byte k of each packet carries the value k.
        for (int v = 0; v < 5; v++) begin
            clear_all();
            send_pkt(vecs[v].nbeats, vecs[v].last_bytes, 1'b0, 1'b0);
            wait_idle(6);
            check($sformatf("vec%0d_nout", v), B'(obs_q.size()), B'(vecs[v].n_out));
            check($sformatf("vec%0d_nhdr", v), B'(obs_hdr.size()), B'(vecs[v].n_hdr));
            check($sformatf("vec%0d_nerr", v), B'(obs_err), B'(vecs[v].n_err));
            for (int k = 0; k < vecs[v].n_out && k < obs_q.size(); k++) begin
                kexp = (k == 0) ? vecs[v].keep0 : vecs[v].keep1;
                dexp = '0;
                for (int j = 0; j < BB; j++) if (kexp[j]) dexp[8*j +: 8] = 8'(HB + BB*k + j);
                check($sformatf("vec%0d_keep%0d", v, k), B'(obs_q[k].keep), B'(kexp));
                check($sformatf("vec%0d_last%0d", v, k), B'(obs_q[k].last),
                      B'((k == 0) ? vecs[v].last0 : vecs[v].last1));
                check($sformatf("vec%0d_data%0d", v, k), obs_q[k].data & keep_mask(kexp), dexp);
            end
            if (vecs[v].n_hdr > 0 && obs_hdr.size() > 0) begin
                for (int i = 0; i < HB; i++) hexp[8*i +: 8] = 8'(i);
                check($sformatf("vec%0d_header", v), B'(obs_hdr[0]), B'(hexp));
            end
        end

        // Reset in the middle of a packet, then a fresh packet.
        clear_all();
        begin
            logic [B-1:0] d;
            for (int j = 0; j < BB; j++) d[8*j +: 8] = 8'hA0 ^ 8'(j);
            drive_beat(d, '1, 1'b0, 1'b0);
            drive_beat(~d, '1, 1'b0, 1'b0);
        end
        #2;
        reset = 1'b1;
        #1;
        check("midrst_tvalid_out", B'(bus.tvalid_out), B'(0));
        check("midrst_tdata_out", bus.tdata_out, B'(0));
        check("midrst_tkeep_out", B'(bus.tkeep_out), B'(0));
        check("midrst_header_data", B'(bus.header_data), B'(0));
        check("midrst_header_valid", B'(bus.header_valid), B'(0));
        check("midrst_tready_out", B'(bus.tready_out), B'(0));
        wait_idle(1);
        check("midrst_tready_held", B'(bus.tready_out), B'(0));
        reset = 1'b0;
        wait_idle(1);
        clear_all();
        send_pkt(2, 30, 1'b1, 1'b0);
        send_pkt(1, 40, 1'b1, 1'b0);
        wait_idle(6);
        compare_streams("post_reset");

        // Randomized traffic with random source gaps and sink backpressure.
        clear_all();
        rnd_ready = 1'b1;
        for (int p = 0; p < 100; p++)
            send_pkt($urandom_range(3, 1), $urandom_range(BB, 1), 1'b1, 1'b1);
        rnd_ready = 1'b0;
        wait_idle(20);
        compare_streams("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
